packer_3way: RTL and testbench
==============================

PACKER_3WAY -- requirements
Module: packer_3way

Interface
- REQ-001: Parameter DEPTH, 8, queue entries; power of two, at least 4.
- REQ-002: Parameter TIMEOUT, 4, idle cycles allowed with 1-2 bytes held before a forced drain; at least 1.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: data_in  input  8  serial byte from producer.
- REQ-006: valid_in  input  1  data_in is valid this cycle.
- REQ-007: ready_in  output  1  packer accepts data_in this cycle.
- REQ-008: flush  input  1  one-cycle request to drain all held bytes.
- REQ-009: able_in  input  3  per-lane acceptance returned by the downstream 3-way FIFO.
- REQ-010: data_out_0, data_out_1, data_out_2  output  8 each  lanes 0..2, oldest byte on lane 0.
- REQ-011: valid_out  output  3  lane valid mask to the FIFO; always a contiguous prefix (000, 001, 011, 111).
- REQ-012: count  output  log2(DEPTH)+1  bytes currently held.

Function
- REQ-013: The block SHALL hold bytes in a DEPTH-entry circular queue with rd_ptr and wr_ptr, each log2(DEPTH) bits wide, wrapping modulo DEPTH.
- REQ-014: ready_in SHALL equal (count < DEPTH), computed from the registered count.
- REQ-015: A push SHALL occur when valid_in & ready_in; data_in is written at wr_ptr, and wr_ptr advances by 1.
- REQ-016: data_out_k SHALL equal queue[rd_ptr+k mod DEPTH] combinationally; lanes with valid_out[k]=0 carry don't-care data.
- REQ-017: pop SHALL equal the number of contiguous ones from bit 0 of (able_in & valid_out); bits above the first zero are ignored (able_in=101 pops 1).
- REQ-018: rd_ptr SHALL advance by pop.
- REQ-019: count_next SHALL equal count + push - pop, including simultaneous push and pop.
- REQ-020: The FSM SHALL have three states: IDLE, ACCUM and DRAIN.
- REQ-021: IDLE: count==0 and valid_out=000; a push moves the FSM to ACCUM.
- REQ-022: ACCUM: valid_out=111 when count>=3, otherwise 000.
- REQ-023: ACCUM: a timer SHALL increment each cycle that count is 1 or 2 and pop==0.
- REQ-024: ACCUM: the timer SHALL clear on any pop, when count>=3, or when count==0.
- REQ-025: ACCUM to DRAIN SHALL occur when the timer equals TIMEOUT-1 with count in 1..2, or when flush is asserted.
- REQ-026: ACCUM to IDLE SHALL occur when count_next==0.
- REQ-027: DRAIN: valid_out SHALL be the prefix mask of min(count,3); pushes continue to be accepted.
- REQ-028: DRAIN to IDLE SHALL occur when count_next==0.
- REQ-029: flush in IDLE SHALL be ignored; flush in DRAIN SHALL have no effect.
- REQ-030: When full (count==DEPTH), ready_in=0; a same-cycle pop does not enable a push in that cycle.
- REQ-031: valid_out SHALL never assert a lane beyond count.
- REQ-032: Bytes SHALL be delivered in arrival order, with none lost or duplicated.

Reset
- REQ-033: While reset=0: rd_ptr=0, wr_ptr=0, count=0, timer=0, state=IDLE, valid_out=000 and ready_in=1, independent of clk.
- REQ-034: Assertion of reset mid-operation SHALL discard all held bytes; queue contents need not be cleared.
- REQ-035: The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
- REQ-036: Push 0x11, 0x22, 0x33 on consecutive cycles with able_in=111 -> the cycle after the third push shows valid_out=111 with lanes 0x11/0x22/0x33; the next cycle shows count=0, state IDLE.
- REQ-037: Push 0xA0, 0xA1, then idle with able_in=111, TIMEOUT=4 -> valid_out=000 for 4 cycles, then 011 with 0xA0/0xA1; count=0 the following cycle.
- REQ-038: Hold 5 bytes B0..B4 and pulse flush with able_in=001, then 101, then 111 -> pops of 1, 1 and 3 in turn; lane 0 shows B0, then B1, then B2; IDLE at the end.
- REQ-039: Push 9 bytes with able_in=000 -> ready_in=0 after the 8th, the 9th is not accepted, count=8; then able_in=111 -> the next pops are bytes 1-3 in order.
- REQ-040: Push and pop 20 bytes continuously, with able_in randomly 001, 011 or 111 -> in-order delivery across pointer wrap; count never exceeds 8.
- REQ-041: Assert reset with count=5 in DRAIN -> valid_out=000 and count=0 immediately; after release, a new byte 0x5A then drains via timeout as 001 with 0x5A.

Source files
------------

// File: rtl/packer_3way.sv
// Byte packer: serial bytes in, up to three bytes out per cycle to a 3-lane FIFO.
// Partial groups of 1-2 bytes are drained after a timeout or on flush.
module packer_3way #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               data_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic                     flush,
  input  logic [2:0]               able_in,
  output logic [7:0]               data_out_0,
  output logic [7:0]               data_out_1,
  output logic [7:0]               data_out_2,
  output logic [2:0]               valid_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_next;
  logic            w_push;
  logic [1:0]      w_pop;
  logic [2:0]      w_avail;
  logic            w_partial;
  logic            w_timeout;
  logic [AW-1:0]   w_idx1;
  logic [AW-1:0]   w_idx2;

  assign count     = r_count;
  assign ready_in  = (r_count < CW'(DEPTH));
  assign w_push    = valid_in & ready_in;
  assign w_partial = (r_count == CW'(1)) || (r_count == CW'(2));
  assign w_timeout = w_partial && (r_timer == TW'(TIMEOUT - 1));

  assign w_idx1     = r_rd_ptr + AW'(1);
  assign w_idx2     = r_rd_ptr + AW'(2);
  assign data_out_0 = r_mem[r_rd_ptr];
  assign data_out_1 = r_mem[w_idx1];
  assign data_out_2 = r_mem[w_idx2];

  // Only the leading run of accepted lanes pops; a gap stops the group.
  always_comb begin
    w_avail = able_in & valid_out;
    if (w_avail[0] && w_avail[1] && w_avail[2]) begin
      w_pop = 2'd3;
    end else if (w_avail[0] && w_avail[1]) begin
      w_pop = 2'd2;
    end else if (w_avail[0]) begin
      w_pop = 2'd1;
    end else begin
      w_pop = 2'd0;
    end
  end

  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // Queue storage carries no reset: stale entries are never shown as valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_timer  <= '0;
      r_state  <= S_IDLE;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_count  <= w_count_next;
      r_timer  <= w_timer_next;
      r_state  <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = '0;
    case (r_state)
      S_IDLE: begin
        if (w_push) begin
          w_state_next = S_ACCUM;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (w_count_next == '0) begin
          w_state_next = S_IDLE;
        end else if (flush || w_timeout) begin
          w_state_next = S_DRAIN;
        end else begin
          w_state_next = S_ACCUM;
          if (w_partial && (w_pop == 2'd0)) begin
            w_timer_next = r_timer + TW'(1);
          end else begin
            w_timer_next = '0;
          end
        end
      end
      S_DRAIN: begin
        if (w_count_next == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DRAIN;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Lane mask is always a prefix and never exceeds the held byte count.
  always_comb begin
    valid_out = 3'b000;
    case (r_state)
      S_IDLE: begin
        valid_out = 3'b000;
      end
      S_ACCUM: begin
        if (r_count >= CW'(3)) begin
          valid_out = 3'b111;
        end else begin
          valid_out = 3'b000;
        end
      end
      S_DRAIN: begin
        if (r_count >= CW'(3)) begin
          valid_out = 3'b111;
        end else if (r_count == CW'(2)) begin
          valid_out = 3'b011;
        end else if (r_count == CW'(1)) begin
          valid_out = 3'b001;
        end else begin
          valid_out = 3'b000;
        end
      end
      default: begin
        valid_out = 3'b000;
      end
    endcase
  end

endmodule

// File: tb/tb_packer_3way.sv
// Self-checking bench for packer_3way: constant vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_packer_3way;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic       flush;
  logic [2:0] able_in;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic [2:0] valid_out;
  logic [3:0] count;
  logic [7:0] dout [3];

  packer_3way #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .flush(flush), .able_in(able_in),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .valid_out(valid_out), .count(count)
  );

  always #5 clk = ~clk;

  assign dout[0] = data_out_0;
  assign dout[1] = data_out_1;
  assign dout[2] = data_out_2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a byte queue plus mode (0 idle, 1 accumulate, 2 drain).
  byte unsigned mq[$];
  int  m_st, m_tmr, m_lanes, m_pop;
  bit  m_push;

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic       fl;
    logic [2:0] able;
    logic [2:0] ev;
    int         ec;
    logic [7:0] e0, e1, e2;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_st = 0; m_tmr = 0; m_pop = 0; m_push = 1'b0; m_lanes = 0;
  endtask

  task automatic drive(input logic vin, input logic [7:0] din, input logic fl, input logic [2:0] able);
    int n, k;
    logic [2:0] m;
    @(negedge clk);
    valid_in = vin; data_in = din; flush = fl; able_in = able;
    #1;
    n = mq.size();
    if (m_st == 0)      m_lanes = 0;
    else if (m_st == 1) m_lanes = (n >= 3) ? 3 : 0;
    else                m_lanes = (n >= 3) ? 3 : n;
    m_pop = 0;
    k = 0;
    while (k < m_lanes && able[k]) begin m_pop++; k++; end
    m_push = vin && (n < DEPTH);
    m = 3'b000;
    for (int j = 0; j < m_lanes; j++) m[j] = 1'b1;
    chk("valid_out", valid_out, m);
    chk("ready_in", ready_in, n < DEPTH);
    chk("count", count, n);
    for (int j = 0; j < m_lanes; j++) chk($sformatf("lane%0d", j), dout[j], mq[j]);
  endtask

  task automatic tick();
    int n, nn;
    n = mq.size();
    @(posedge clk);
    for (int j = 0; j < m_pop; j++) void'(mq.pop_front());
    if (m_push) mq.push_back(data_in);
    nn = mq.size();
    case (m_st)
      0: if (m_push) m_st = 1;
      1: begin
        if (nn == 0) begin m_st = 0; m_tmr = 0; end
        else if (flush || (n >= 1 && n <= 2 && m_tmr == TIMEOUT - 1)) begin m_st = 2; m_tmr = 0; end
        else if (m_pop == 0 && n >= 1 && n <= 2) m_tmr++;
        else m_tmr = 0;
      end
      default: if (nn == 0) m_st = 0;
    endcase
  endtask

  task automatic step(input logic vin, input logic [7:0] din, input logic fl, input logic [2:0] able);
    drive(vin, din, fl, able);
    tick();
  endtask

  task automatic drain_all();
    int guard = 0;
    while ((mq.size() != 0 || m_st != 0) && guard < 40) begin
      step(1'b0, 8'h00, 1'b0, 3'b111);
      guard++;
    end
    chk("drain_bounded", guard < 40, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, guard;
    logic [2:0] ables [3];
    ables[0] = 3'b001; ables[1] = 3'b011; ables[2] = 3'b111;

    // {vin, din, flush, able, expected valid_out, expected count, lanes 0..2}
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 3'b111, 3'b000, 0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 3'b111, 3'b000, 1, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 3'b111, 3'b000, 2, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 3'b111, 3'b111, 3, 8'h11, 8'h22, 8'h33};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 3'b111, 3'b000, 0, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{1'b1, 8'hA0, 1'b0, 3'b111, 3'b000, 0, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{1'b1, 8'hA1, 1'b0, 3'b111, 3'b000, 1, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 3'b111, 3'b000, 2, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 3'b111, 3'b000, 2, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 3'b111, 3'b000, 2, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 3'b111, 3'b011, 2, 8'hA0, 8'hA1, 8'h00};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 3'b111, 3'b000, 0, 8'h00, 8'h00, 8'h00};

    reset = 1'b0; valid_in = 1'b0; data_in = 8'h00; flush = 1'b0; able_in = 3'b000;
    model_reset();
    #12;
    chk("reset_valid_out", valid_out, 3'b000);
    chk("reset_ready_in", ready_in, 1'b1);
    chk("reset_count", count, 0);
    @(negedge clk);
    reset = 1'b1;

    // Three-byte group and timeout drain of a two-byte partial group
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].vin, tbl[i].din, tbl[i].fl, tbl[i].able);
      chk($sformatf("tbl%0d_valid", i), valid_out, tbl[i].ev);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].ec);
      if (tbl[i].ev[0]) chk($sformatf("tbl%0d_lane0", i), data_out_0, tbl[i].e0);
      if (tbl[i].ev[1]) chk($sformatf("tbl%0d_lane1", i), data_out_1, tbl[i].e1);
      if (tbl[i].ev[2]) chk($sformatf("tbl%0d_lane2", i), data_out_2, tbl[i].e2);
      tick();
    end

    // Flush with partial lane acceptance: pops 1, 1, 3
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 3'b000);
    drive(1'b0, 8'h00, 1'b1, 3'b001);
    chk("flush_lane0_b0", data_out_0, 8'hB0);
    chk("flush_count5", count, 5);
    tick();
    drive(1'b0, 8'h00, 1'b0, 3'b101);
    chk("gap_lane0_b1", data_out_0, 8'hB1);
    chk("gap_valid", valid_out, 3'b111);
    tick();
    drive(1'b0, 8'h00, 1'b0, 3'b111);
    chk("last_lane0_b2", data_out_0, 8'hB2);
    chk("last_lane2_b4", data_out_2, 8'hB4);
    tick();
    drive(1'b0, 8'h00, 1'b0, 3'b111);
    chk("flush_empty_count", count, 0);
    chk("flush_empty_valid", valid_out, 3'b000);
    tick();

    // Full queue: ninth byte refused, then oldest three delivered
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'(8'hC0 + i), 1'b0, 3'b000);
      if (i == 8) begin
        chk("full_ready", ready_in, 1'b0);
        chk("full_count", count, 8);
      end
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 3'b111);
    chk("full_lane0", data_out_0, 8'hC0);
    chk("full_lane1", data_out_1, 8'hC1);
    chk("full_lane2", data_out_2, 8'hC2);
    tick();
    drain_all();

    // Randomized traffic across pointer wrap
    pushed = 0;
    guard  = 0;
    while (pushed < 20 && guard < 300) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
            ables[$urandom_range(0, 2)]);
      chk("count_bound", count <= 4'd8, 1'b1);
      if (m_push) pushed++;
      tick();
      guard++;
    end
    chk("random_pushed", pushed, 20);
    drain_all();

    // Reset while draining five bytes, then timeout drain of one new byte
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 3'b000);
    step(1'b0, 8'h00, 1'b1, 3'b000);
    drive(1'b0, 8'h00, 1'b0, 3'b000);
    chk("pre_reset_count", count, 5);
    #1;
    reset = 1'b0;
    #1;
    chk("midreset_valid", valid_out, 3'b000);
    chk("midreset_count", count, 0);
    chk("midreset_ready", ready_in, 1'b1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 3'b111);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 3'b111);
    drive(1'b0, 8'h00, 1'b0, 3'b111);
    chk("post_reset_valid", valid_out, 3'b001);
    chk("post_reset_lane0", data_out_0, 8'h5A);
    tick();
    drive(1'b0, 8'h00, 1'b0, 3'b111);
    chk("post_reset_empty", count, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
